// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM states.
// The ST_MUL state is only reachable when ALU_MUL_EN is defined.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MUL  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle for WIDTH cycles.
// Compiled only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] step;

    // product is the accumulator after the current step, so it is final while done is high
    assign step    = mplier[0] ? mcand : '0;
    assign product = acc + step;
    assign done    = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a registered result/zero flag.
// Define ALU_MUL_EN to enable the iterative multiply for code 011.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    alu_state_e       state, state_next;
    logic [WIDTH-1:0] result_next;
    logic             zero_next;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf;

    assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_HOLD);

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;
    // signed a<b is sign(a-b) corrected by subtraction overflow
    assign ovf  = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);

    always_comb begin
        alu_out = '0;
        case (alu_control)
            ALU_AND: alu_out = src_a & src_b;
            ALU_OR:  alu_out = src_a | src_b;
            ALU_ADD: alu_out = sum;
            ALU_SUB: alu_out = diff;
            ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf};
            default: alu_out = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign is_mul    = (alu_control == ALU_MUL);
    assign mul_start = accept && is_mul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        result_next = result;
        zero_next   = zero;
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        state_next = ST_MUL;
                    end else begin
                        state_next  = ST_HOLD;
                        result_next = alu_out;
                        zero_next   = (alu_out == '0);
                    end
                end else if (state == ST_HOLD && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_next  = ST_HOLD;
                    result_next = mul_product;
                    zero_next   = (mul_product == '0);
                end else if (!mul_busy) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            state  <= state_next;
            result <= result_next;
            zero   <= zero_next;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec; MUL vectors are selected by ALU_MUL_EN.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_exec #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge, then drop valid and scramble operands.
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_control = c;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'h1234_5678;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = 3'b000;
        src_a       = '0;
        src_b       = '0;
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // ADD wraps into the sign bit
        issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_out_valid", {31'b0, out_valid}, 32'd1);
        check("add_result", result, 32'h8000_0000);
        check("add_zero", {31'b0, zero}, 32'd0);

        // back-to-back SUB then SLT
        issue(3'b110, 32'd5, 32'd5);
        check("sub_result", result, 32'd0);
        check("sub_zero", {31'b0, zero}, 32'd1);
        check("sub_in_ready", {31'b0, in_ready}, 32'd1);
        issue(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt_neg_result", result, 32'd1);
        check("slt_neg_zero", {31'b0, zero}, 32'd0);
        check("slt_neg_valid", {31'b0, out_valid}, 32'd1);

        issue(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
        check("slt_ovf_result", result, 32'd0);
        check("slt_ovf_zero", {31'b0, zero}, 32'd1);
        issue(3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_ovf2_result", result, 32'd1);
        issue(3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
        check("and_result", result, 32'h0000_00F0);

        // stall: result held, in_ready low, new inputs ignored
        issue(3'b001, 32'h1, 32'h2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_control = 3'b010;
            src_a       = 32'd100;
            src_b       = 32'd200;
            in_valid    = 1'b1;
            #1;
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_result", result, 32'h3);
            tick();
        end
        check("stall_result_end", result, 32'h3);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("release_result", result, 32'd300);

        // drain to IDLE
        tick();
        check("drain_out_valid", {31'b0, out_valid}, 32'd0);
        check("drain_in_ready", {31'b0, in_ready}, 32'd1);

        issue(3'b100, 32'h0000_FFFF, 32'h1);
        check("rsv100_valid", {31'b0, out_valid}, 32'd1);
        check("rsv100_result", result, 32'd0);
        check("rsv100_zero", {31'b0, zero}, 32'd1);
        issue(3'b101, 32'h0000_FFFF, 32'h1);
        check("rsv101_result", result, 32'd0);

`ifdef ALU_MUL_EN
        begin
            int cyc;
            issue(3'b011, 32'd3, 32'd7);
            cyc = 1;
            check("mul_busy_in_ready", {31'b0, in_ready}, 32'd0);
            while (!out_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            check("mul_latency", cyc, 32'd33);
            check("mul_result", result, 32'd21);
            check("mul_zero", {31'b0, zero}, 32'd0);

            issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            while (!out_valid && cyc < 80) begin
                tick();
                cyc++;
            end
            check("mul_wrap_result", result, 32'd1);

            issue(3'b011, 32'd3, 32'd7);
            for (int i = 1; i < 10; i++)
                tick();
            check("mul_mid_out_valid", {31'b0, out_valid}, 32'd0);
            rst = 1'b1;
            tick();
            check("mul_rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("mul_rst_result", result, 32'd0);
            check("mul_rst_in_ready", {31'b0, in_ready}, 32'd0);
            rst = 1'b0;
            cyc = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid)
                    cyc++;
            end
            check("mul_aborted_no_valid", cyc, 32'd0);
            check("mul_aborted_in_ready", {31'b0, in_ready}, 32'd1);
        end
`else
        issue(3'b011, 32'd3, 32'd7);
        check("mul_rsv_valid", {31'b0, out_valid}, 32'd1);
        check("mul_rsv_result", result, 32'd0);
        check("mul_rsv_zero", {31'b0, zero}, 32'd1);
`endif

        // reset while holding a result
        issue(3'b010, 32'd1, 32'd2);
        out_ready = 1'b0;
        check("hold_result", result, 32'd3);
        rst = 1'b1;
        tick();
        check("hold_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("hold_rst_result", result, 32'd0);
        check("hold_rst_zero", {31'b0, zero}, 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
